// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      ACK   = 3'd5
   } uart_state_t;

   localparam int unsigned BAUD_TERM_DEF = 5208;
   localparam int unsigned DATA_BITS     = 8;
   localparam int unsigned TIMER_W       = 13;

   // Parity bit that makes the total count of ones in data+parity odd.
   function automatic logic odd_par(input logic [DATA_BITS-1:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - free-running bit-period timer with clear and two terminal matches
module uart_baud_timer #(
   parameter int unsigned W = 13
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         clr,
   input  logic [W-1:0] term,
   input  logic [W-1:0] half,
   output logic         at_term,
   output logic         at_half
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign at_term = (cnt_q == term);
   assign at_half = (cnt_q == half);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr || at_term) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-O-1 UART receiver with mid-bit sampling and Receive/ReceiveAck handshake
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_TERM   = BAUD_TERM_DEF,
   parameter int unsigned HALF_TERM   = BAUD_TERM / 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 Sin,
   input  logic                 ReceiveAck,
   output logic [DATA_BITS-1:0] Dout,
   output logic                 Receive,
   output logic                 parityErr,
   output logic                 frameErr
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sin_s;

   uart_state_t            state_q;
   uart_state_t            state_d;

   logic [2:0]             bit_cnt_q;
   logic [2:0]             bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   shift_d;
   logic                   par_q;
   logic                   par_d;
   logic [DATA_BITS-1:0]   dout_q;
   logic [DATA_BITS-1:0]   dout_d;
   logic                   perr_q;
   logic                   perr_d;
   logic                   ferr_q;
   logic                   ferr_d;

   logic                   clr_timer;
   logic                   at_term;
   logic                   at_half;

   uart_baud_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk     (clk),
      .Reset   (Reset),
      .clr     (clr_timer),
      .term    (TIMER_W'(BAUD_TERM)),
      .half    (TIMER_W'(HALF_TERM)),
      .at_term (at_term),
      .at_half (at_half)
   );

   // Synchroniser: idle-high line, so every stage resets to 1.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], Sin};
   assign sin_s  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (Reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!sin_s) state_d = START;
         START:   if (at_half) state_d = sin_s ? IDLE : BITS;
         BITS:    if (at_term && (bit_cnt_q == 3'd7)) state_d = PAR;
         PAR:     if (at_term) state_d = STOP;
         STOP:    if (at_term) state_d = ACK;
         ACK:     if (ReceiveAck) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The half-bit match in START re-phases the timer to mid-bit for all later samples.
   always_comb begin
      clr_timer = (state_q == IDLE) || ((state_q == START) && at_half);
      Receive   = (state_q == ACK);
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      dout_d    = dout_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      if ((state_q == START) && at_half) begin
         bit_cnt_d = '0;
      end
      if ((state_q == BITS) && at_term) begin
         shift_d = {sin_s, shift_q[DATA_BITS-1:1]};
         if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end
      if ((state_q == PAR) && at_term) begin
         par_d = sin_s;
      end
      // A bad stop bit still delivers the byte, flagged.
      if ((state_q == STOP) && at_term) begin
         dout_d = shift_q;
         perr_d = (par_q != odd_par(shift_q));
         ferr_d = ~sin_s;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         dout_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         dout_q    <= dout_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign Dout      = dout_q;
   assign parityErr = perr_q;
   assign frameErr  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - uart_rx bench: transmitter model, frame scoreboard, per-cycle output compare
module tb_uart_rx;

   localparam int BT = 31;
   localparam int HT = BT / 2;
   localparam int SS = 2;
   localparam int P  = BT + 1;
   // Receive rises one clk after the stop sample, which is 10 bit periods after the start check.
   localparam int LAT = SS + 1 + (HT + 1) + 10 * P;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         rise;
   } exp_t;

   logic       clk = 1'b0;
   logic       Reset;
   logic       Sin;
   logic       ack_tied;
   logic       ack_pulse;
   logic       ack;
   logic [7:0] Dout;
   logic       Receive;
   logic       parityErr;
   logic       frameErr;

   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   exp_t       q[$];
   logic [7:0] last_data = 8'h00;
   logic       last_perr = 1'b0;
   logic       last_ferr = 1'b0;
   logic       rx_prev = 1'b0;
   logic       ack_prev = 1'b0;
   int         last_t0 = 0;
   int         last_rise = 0;

   assign ack = ack_tied | ack_pulse;

   uart_rx #(
      .BAUD_TERM   (BT),
      .HALF_TERM   (HT),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .Sin        (Sin),
      .ReceiveAck (ack),
      .Dout       (Dout),
      .Receive    (Receive),
      .parityErr  (parityErr),
      .frameErr   (frameErr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Team transmitter model; pc is the bit period in hundredths of a clk.
   task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                             input int pc, input bit expect_it);
      logic        par;
      logic [10:0] bits;
      int          t0;
      exp_t        e;
      par = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
      if (bad_par) par = ~par;
      bits = {~bad_stop, par, data, 1'b0};
      @(posedge clk); #1;
      t0 = cyc;
      last_t0 = t0;
      if (expect_it) begin
         e.data = data;
         e.perr = (($countones(data) + int'(par)) % 2 == 0);
         e.ferr = bad_stop;
         e.rise = (pc == P * 100) ? t0 + LAT : -1;
         q.push_back(e);
      end
      for (int k = 0; k < 11; k++) begin
         Sin = bits[k];
         while (cyc - t0 < ((k + 1) * pc) / 100) begin
            @(posedge clk); #1;
         end
      end
      Sin = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drained(input string name);
      for (int i = 0; i < 4 * P && q.size() != 0; i++) @(posedge clk);
      #1;
      chk(name, q.size(), 0);
   endtask

   // Consumer: acknowledge 5 clk after Receive is seen.
   initial begin
      ack_pulse = 1'b0;
      forever begin
         @(negedge clk);
         if (Receive && !ack_tied && !Reset) begin
            repeat (5) @(posedge clk);
            #1 ack_pulse = 1'b1;
            @(posedge clk);
            #1 ack_pulse = 1'b0;
         end
      end
   end

   // Compare process: every cycle out of reset, outputs must match the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (Reset) begin
            last_data = 8'h00;
            last_perr = 1'b0;
            last_ferr = 1'b0;
            rx_prev   = 1'b0;
            ack_prev  = 1'b0;
         end else begin
            if (Receive && !rx_prev) begin
               last_rise = cyc;
               if (q.size() == 0) begin
                  chk("spurious_receive", 1, 0);
               end else begin
                  e = q.pop_front();
                  last_data = e.data;
                  last_perr = e.perr;
                  last_ferr = e.ferr;
                  if (e.rise >= 0) chk("receive_latency", cyc, e.rise);
               end
            end
            if (rx_prev && !Receive) chk("receive_fell_without_ack", int'(ack_prev), 1);
            if (rx_prev && Receive) chk("receive_held_after_ack", int'(ack_prev), 0);
            chk("dout", int'(Dout), int'(last_data));
            chk("parity_err", int'(parityErr), int'(last_perr));
            chk("frame_err", int'(frameErr), int'(last_ferr));
            rx_prev  = Receive;
            ack_prev = ack;
         end
      end
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rates[3];
      rates = '{P * 100, P * 102, P * 98};
      Reset     = 1'b1;
      Sin       = 1'b1;
      ack_tied  = 1'b0;
      idle_cycles(4);
      Reset = 1'b0;
      idle_cycles(2);
      chk("reset_dout", int'(Dout), 0);
      chk("reset_receive", int'(Receive), 0);
      chk("reset_perr", int'(parityErr), 0);
      chk("reset_ferr", int'(frameErr), 0);

      send_frame(8'h55, 0, 0, P * 100, 1);
      wait_drained("t1_drain");
      chk("t1_dout", int'(Dout), 'h55);
      chk("t1_latency", last_rise - last_t0, 339);
      idle_cycles(10);

      send_frame(8'hA3, 1, 0, P * 100, 1);
      wait_drained("t2_drain");
      chk("t2_dout", int'(Dout), 'hA3);
      chk("t2_perr", int'(parityErr), 1);
      idle_cycles(10);

      send_frame(8'h00, 0, 1, P * 100, 1);
      wait_drained("t3_drain");
      chk("t3_ferr", int'(frameErr), 1);
      chk("t3_perr", int'(parityErr), 0);
      idle_cycles(2 * P);

      for (int g = 0; g < 4; g++) begin
         Sin = 1'b0;
         idle_cycles(1 + int'($urandom_range(0, HT - 4)));
         Sin = 1'b1;
         idle_cycles(2 * P);
      end
      chk("t4_receive", int'(Receive), 0);
      chk("t4_dout", int'(Dout), 'h00);

      fork
         send_frame(8'hFF, 0, 0, P * 100, 0);
         begin
            idle_cycles(5 * P + 17);
            Reset = 1'b1;
            idle_cycles(2);
            Reset = 1'b0;
         end
      join
      idle_cycles(10);
      chk("t5_dout_after_reset", int'(Dout), 0);
      send_frame(8'h3C, 0, 0, P * 100, 1);
      wait_drained("t5_drain");
      chk("t5_dout", int'(Dout), 'h3C);
      idle_cycles(10);

      ack_tied = 1'b1;
      send_frame(8'h01, 0, 0, P * 100, 1);
      send_frame(8'h80, 0, 0, P * 100, 1);
      send_frame(8'hFF, 0, 0, P * 100, 1);
      wait_drained("t6_drain");
      chk("t6_dout", int'(Dout), 'hFF);
      idle_cycles(10);
      ack_tied = 1'b0;

      send_frame(8'h96, 0, 0, P * 102, 1);
      wait_drained("t7_slow_drain");
      idle_cycles(10);
      send_frame(8'h96, 0, 0, P * 98, 1);
      wait_drained("t7_fast_drain");
      chk("t7_dout", int'(Dout), 'h96);
      idle_cycles(10);

      for (int n = 0; n < 16; n++) begin
         send_frame(8'($urandom), ($urandom_range(0, 3) == 0), 0,
                    rates[$urandom_range(0, 2)], 1);
         idle_cycles(10 + int'($urandom_range(0, 20)));
      end
      wait_drained("random_drain");
      idle_cycles(2 * P);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
